// File: rtl/score_disp_pkg.sv
// rtl/score_disp_pkg.sv - shared types, constants and segment encoding for score_display
package score_disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_e;

  localparam int BCD_ITER = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low cathode patterns, bit 0 = CA .. bit 6 = CG
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    return (digit > 4'd9) ? SEG_BLANK : SEG_DIGIT[digit];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 converter from 6-bit binary to two BCD digits
module bin2bcd_seq
  import score_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy
);

  conv_state_e state_q, state_d;
  logic [13:0] sr_q, sr_d;
  logic [2:0]  iter_q, iter_d;
  logic [5:0]  last_q, last_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [13:0] adj;
  logic [13:0] shifted;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    last_d  = last_q;
    tens_d  = tens_q;
    ones_d  = ones_q;

    // Shift register layout: {tens[13:10], ones[9:6], binary[5:0]}
    adj = sr_q;
    if (sr_q[13:10] >= 4'd5) adj[13:10] = sr_q[13:10] + 4'd3;
    if (sr_q[9:6] >= 4'd5)   adj[9:6]   = sr_q[9:6] + 4'd3;
    shifted = {adj[12:0], 1'b0};

    case (state_q)
      IDLE: begin
        if (bin != last_q) begin
          sr_d    = {8'd0, bin};
          iter_d  = 3'd0;
          last_d  = bin;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d   = shifted;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'(BCD_ITER - 1)) begin
          tens_d  = shifted[13:10];
          ones_d  = shifted[9:6];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      iter_q  <= '0;
      last_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
      last_q  <= last_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;
  assign busy = (state_q == CONV);

endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - scans the BCD score onto a 4-digit common-anode display with win blink
module score_display
  import score_disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLINK_CYCLES = 25000000,
  parameter int WIN_SCORE    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] score,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(DIGIT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       conv_busy_unused;

  bin2bcd_seq u_conv (
    .clk  (clk),
    .rst  (rst),
    .bin  (score),
    .tens (bcd_tens),
    .ones (bcd_ones),
    .busy (conv_busy_unused)
  );

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  blink_phase_e  phase_q, phase_d;
  logic          win_q, win_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    bcd_value;
  logic          win;
  logic          blank_all;

  assign bcd_value = 7'(bcd_tens) * 7'd10 + 7'(bcd_ones);
  assign win       = (bcd_value == 7'(WIN_SCORE));

  always_comb begin
    scan_cnt_d  = scan_cnt_q + SW'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    win_d       = win;
    an_d        = 4'hF;
    seg_d       = SEG_BLANK;

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end

    // A fresh win restarts the blink cycle in the visible phase
    if (!win || !win_q) begin
      blink_cnt_d = '0;
      phase_d     = PHASE_ON;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end

    // Uses live win so a score drop un-blanks without waiting on the phase register
    blank_all = win && (phase_q == PHASE_OFF);
    if (!blank_all) begin
      case (idx_q)
        2'd0: begin
          an_d  = 4'b1110;
          seg_d = seg_encode(bcd_ones);
        end
        2'd1: begin
          if (bcd_tens != 4'd0) begin
            an_d  = 4'b1101;
            seg_d = seg_encode(bcd_tens);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= PHASE_ON;
      win_q       <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= 4'hF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      win_q       <= win_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - directed self-checking bench for score_display
module tb_score_display;

  localparam int DC = 4;
  localparam int BC = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] score = 6'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  score_display #(
    .DIGIT_CYCLES (DC),
    .BLINK_CYCLES (BC),
    .WIN_SCORE    (60)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .score (score),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bcd(input string tag, input logic [7:0] exp);
    check(tag, {8'h00, dut.bcd_tens, dut.bcd_ones}, {8'h00, exp});
  endtask

  // Compares {an,seg,dp} every cycle for n cycles; the active slot follows the scan timing since reset
  task automatic check_window(input string tag, input int n, input int t, input int o, input bit blank);
    logic [15:0] obs, exp, obs_c, exp_c;
    bit caught;
    int slot;
    caught = 1'b0;
    obs_c  = '0;
    exp_c  = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      slot = ((cyc - 1) / DC) % 4;
      exp  = {4'h0, 4'hF, 7'h7F, 1'b1};
      if (!blank) begin
        if (slot == 0) exp = {4'h0, 4'b1110, pat(o), 1'b1};
        else if (slot == 1 && t != 0) exp = {4'h0, 4'b1101, pat(t), 1'b1};
      end
      obs = {4'h0, an, seg, dp};
      if (!caught) begin
        obs_c = obs;
        exp_c = exp;
        if (obs !== exp) caught = 1'b1;
      end
    end
    check(tag, obs_c, exp_c);
  endtask

  initial begin
    rst = 1'b1;
    score = 6'd0;
    step(3);
    check("rst_out", {4'h0, an, seg, dp}, {4'h0, 4'hF, 7'h7F, 1'b1});
    check_bcd("rst_bcd", 8'h00);
    rst = 1'b0;
    check_window("idle0", 16, 0, 0, 0);

    score = 6'd37;
    step(6);
    check_bcd("lat37_early", 8'h00);
    step(1);
    check_bcd("lat37", 8'h37);
    check_window("disp37", 16, 3, 7, 0);

    score = 6'd5;
    step(10);
    check_bcd("bcd05", 8'h05);
    score = 6'd9;
    step(2);
    score = 6'd12;
    step(5);
    check_bcd("glitch09", 8'h09);
    check_window("disp09", 6, 0, 9, 0);
    check_bcd("glitch_hold", 8'h09);
    step(1);
    check_bcd("glitch12", 8'h12);
    check_window("disp12", 16, 1, 2, 0);

    score = 6'd60;
    step(7);
    check_bcd("bcd60", 8'h60);
    check_window("win_on1", 33, 6, 0, 0);
    check_window("win_off1", 32, 6, 0, 1);
    check_window("win_on2", 32, 6, 0, 0);
    step(10);
    score = 6'd59;
    step(7);
    check_bcd("bcd59", 8'h59);
    check_window("unblank59", 80, 5, 9, 0);

    score = 6'd45;
    step(3);
    rst = 1'b1;
    step(1);
    check("rstmid_out", {4'h0, an, seg, dp}, {4'h0, 4'hF, 7'h7F, 1'b1});
    check_bcd("rstmid_bcd", 8'h00);
    rst = 1'b0;
    step(6);
    check_bcd("rst45_early", 8'h00);
    step(1);
    check_bcd("rst45", 8'h45);
    check_window("disp45", 16, 4, 5, 0);

    for (int s = 0; s < 64; s++) begin
      score = 6'(s);
      step(8);
      check_bcd($sformatf("sweep_bcd%0d", s), {4'(s / 10), 4'(s % 10)});
      check_window($sformatf("sweep_disp%0d", s), 12, s / 10, s % 10, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream of the whack-a-mole game FSM on the Basys 3.
- Takes the FSM's 6-bit binary score and converts it sequentially to two BCD digits.
- Drives the 4-digit common-anode seven-segment display by time-multiplexed scanning.
- Blanks unused and leading-zero digits, and blinks the whole display once the final score is reached.

Parameters:
- DIGIT_CYCLES, 100000, clk cycles each digit slot stays active (1 ms at 100 MHz).
- BLINK_CYCLES, 25000000, clk cycles per blink phase (on or off) in the win condition.
- WIN_SCORE, 60, converted score value that triggers blinking.

Ports:
- clk    in   1  system clock, 100 MHz
- rst    in   1  reset, synchronous, active-high
- score  in   6  binary score from the game FSM (0..63)
- seg    out  7  segment cathodes, active-low; seg[0]=CA .. seg[6]=CG
- dp     out  1  decimal point cathode, active-low; held 1 (off) at all times
- an     out  4  digit anodes, active-low; an[0]=rightmost digit

Behaviour:
- Reset (rst=1 at a clk edge):
  - seg=7'h7F, an=4'hF, dp=1.
  - Converter: IDLE, BCD tens=0, ones=0, last_conv=0.
  - Scan index=0, scan counter=0, blink counter=0, blink phase=ON.
  - rst mid-conversion aborts the conversion; no partial BCD update.
- Converter FSM (sub-module), states IDLE, CONV:
  - IDLE -> CONV when score != last_conv. In that cycle it loads a 14-bit shift register {4'b0,4'b0,score}, sets iteration count=0 and sets last_conv<=score.
  - CONV: each cycle, add 3 to any BCD nibble >=5, then shift left 1 and increment the count.
  - After the 6th CONV cycle: latch tens/ones and return to IDLE.
  - Latency: a score change at edge N starts CONV at edge N+1; BCD updates at edge N+7.
  - A score change during CONV is ignored until IDLE; IDLE then sees the mismatch and restarts. The final BCD always matches the last stable score.
  - Scores 61..63 convert correctly even though unreachable.
- Scan:
  - The counter counts 0..DIGIT_CYCLES-1, then wraps and advances the index 0->1->2->3->0.
  - Slot 0 shows ones (always shown, including 0).
  - Slot 1 shows tens; blanked when tens==0.
  - Slots 2 and 3 are always blank.
- Outputs:
  - Registered, one cycle after the index/BCD change.
  - Active slot: an has a single 0 at bit [index]; seg is the digit pattern.
  - Blank slot: an=4'hF, seg=7'h7F.
- Patterns (seg[6:0], active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Win blink:
  - win = (10*tens+ones == WIN_SCORE).
  - On the rising edge of win: blink counter clears and phase=ON.
  - While win: the counter counts 0..BLINK_CYCLES-1 and toggles phase at wrap. In the OFF phase, an=4'hF and seg=7'h7F.
  - When win falls: phase is forced ON and blinking stops.
- Simultaneous events: a conversion update in the same cycle as a scan wrap means the new slot shows the new BCD value. No glitch beyond the one-cycle register delay.

Decomposition:
- Shared package score_disp_pkg:
  - SEG_DIGIT[0:9] constant array.
  - SEG_BLANK = 7'h7F.
  - Converter state encoding {IDLE, CONV}.
  - BCD_ITER = 6.
- Sub-module bin2bcd_seq:
  - Ports: clk, rst, bin[5:0], tens[3:0], ones[3:0], busy.
  - Holds the converter FSM and last_conv.
- score_display holds the scan counter, blink logic and output registers.

Test Plan (DIGIT_CYCLES=4, BLINK_CYCLES=32 overridden):
- Reset released, score=0:
  - seg=7'h7F and an=4'hF during rst.
  - Afterwards, slot 0 shows an=4'b1110, seg=1000000; slots 1..3 are blank (an=4'hF).
- score 0->37 at edge N:
  - tens=3, ones=7 at edge N+7.
  - Slot 0 shows seg=1111000, an=1110; slot 1 shows seg=0110000, an=1101.
- score 5->9 with a glitch (9->12 during CONV, 2 cycles later):
  - First conversion finishes showing 09 (tens blanked, ones=0010000).
  - A restart follows; 12 is displayed by 14 cycles after the first change.
- score=60:
  - Digits "60" are shown for 32 cycles, then an=4'hF for 32 cycles, repeating.
  - score->59 mid-OFF phase: display is immediately un-blanked after the conversion and never blinks.
- rst asserted at CONV cycle 3 of converting 45:
  - BCD=00 after reset; with score still 45, conversion restarts and shows 45 by 8 cycles after release.
- Sweep score 0..63, each held 20 cycles:
  - tens/ones match score/10 and score%10 every time.
  - dp=1 throughout.
